alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream stage of the 4-bit combinational arithmetic unit.
- Captures the arithmetic unit's Sum/Diff/Prod/Quot/Rem and carry/borrow outputs for the opcode being issued, and selects one 8-bit result.
- Computes status flags, sanitises divide-by-zero, and buffers results in a small FIFO with valid/ready handshakes so the consumer (register file/display) can stall.

Parameters:
- DEPTH, 2, number of result entries buffered; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  operation + arithmetic-unit outputs present this cycle.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- opcode  in  3  0=ADD, 1=SUB, 2=MUL, 3=DIV; 4..7 illegal.
- op_a  in  4  operand A as fed to the arithmetic unit.
- op_b  in  4  operand B as fed to the arithmetic unit (divide-by-zero detect).
- sum  in  4  arithmetic-unit Sum.
- carry_out  in  1  arithmetic-unit carry.
- diff  in  4  arithmetic-unit Diff.
- borrow_out  in  1  arithmetic-unit borrow.
- prod  in  8  arithmetic-unit Prod.
- quot  in  4  arithmetic-unit Quot.
- rem  in  4  arithmetic-unit Rem.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head; pop when out_valid && out_ready.
- res_data  out  8  head result.
- res_flags  out  4  {ill, dz, c, z} of head entry.
- sticky_flags  out  3  {ill, dz, c} accumulated; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at clk edge): count=0, rd/wr pointers=0, out_valid=0, in_ready=0 during reset and 1 the cycle after, res_data=0, res_flags=0, sticky_flags=0. Reset mid-operation discards all buffered entries.
- Result selection at push:
  - ADD: {4'b0,sum}, c=carry_out.
  - SUB: {4'b0,diff}, c=borrow_out.
  - MUL: prod, c=0.
  - DIV: {rem,quot}, c=0.
  - Illegal opcode: data=0, ill=1.
- Divide-by-zero (opcode=3, op_b=0): quot/rem inputs are ignored (they may be X). Data={op_a,4'hF}, dz=1.
- z=1 iff the stored 8-bit data==0. z is also set for the illegal-opcode case.
- FIFO:
  - in_ready = (count != DEPTH), registered from count, no combinational path from out_ready.
  - out_valid = (count != 0).
  - res_data and res_flags are driven from the head entry; they are 0 when empty.
- Latency: an entry pushed at edge N is visible on out_valid/res_data after edge N, i.e. one cycle.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged, both pointers advance.
- Empty + push: no bypass; out_valid rises the next cycle.
- Full: in_ready=0, so in_valid is ignored; a pop while full frees a slot, and in_ready=1 the following cycle.
- Pointers wrap modulo DEPTH.
- Outputs hold stable while out_valid && !out_ready.
- Inputs are sampled only on a push handshake. Data inputs are don't-care otherwise.

Optional Feature:
- Macro: ALU_RESULT_STICKY_EN.
- Defined: sticky_flags ORs {ill, dz, c} of every pushed entry. It clears only on reset.
- Not defined: sticky_flags is constant 0 and no sticky registers are synthesised.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=3'd0, OP_SUB=3'd1, OP_MUL=3'd2, OP_DIV=3'd3.
  - flag bit indices FLG_Z=0, FLG_C=1, FLG_DZ=2, FLG_ILL=3.
  - DZ_QUOT=4'hF.
  - packed typedef alu_res_t {flags[3:0], data[7:0]}.
- One natural sub-module: alu_res_fifo, a generic DEPTH-entry synchronous FIFO of alu_res_t with count/pointers.
- Result selection and flag logic stay in the top module.

Test Plan:
- Reset then ADD a=9,b=8: sum=1, carry_out=1 -> next cycle out_valid=1, res_data=8'h01, flags c=1, z=0.
- DIV a=13,b=0 with quot/rem driven X -> res_data=8'hDF, dz=1; with ALU_RESULT_STICKY_EN, sticky_flags=3'b010 afterward.
- Push 2 entries with out_ready=0 -> in_ready=0 after the 2nd. A 3rd in_valid is ignored. Then pop both -> order preserved: MUL 15*15 → 8'hE1, then SUB 3-5 → 8'h0E with c=1.
- Steady stream in_valid=out_ready=1 for 10 cycles -> one result per cycle, count stays 1, pointers wrap correctly.
- Illegal opcode 3'd6 -> res_data=0, flags ill=1 and z=1; SUB 4-4 → res_data=0, z=1, c=0.
- Assert rst_n=0 with 2 entries buffered -> next cycle out_valid=0, sticky_flags=0, and prior entries are never emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit arithmetic unit result path.
// Opcode encodings, flag bit positions, the divide-by-zero quotient
// filler, and the packed result entry carried through the result FIFO.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam int FLG_Z   = 0;
  localparam int FLG_C   = 1;
  localparam int FLG_DZ  = 2;
  localparam int FLG_ILL = 3;

  localparam logic [3:0] DZ_QUOT = 4'hF;

  typedef struct packed {
    logic [3:0] flags;  // {ill, dz, c, z}
    logic [7:0] data;
  } alu_res_t;

endpackage

// File: rtl/alu_res_fifo.sv
// DEPTH-entry synchronous FIFO of alu_res_t with valid/ready on both sides.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, din           write request / entry; accepted when push && in_ready
//   in_ready            registered "not full" (no path from pop)
//   pop                 read request; accepted when pop && out_valid
//   out_valid, dout     head entry valid / head entry (zero when empty)
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_res_t din,
  output logic     in_ready,
  input  logic     pop,
  output logic     out_valid,
  output alu_res_t dout
);

  alu_res_t           mem [DEPTH];
  logic [PTR_W:0]     count, count_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               do_push, do_pop;

  assign do_push   = push && in_ready;
  assign do_pop    = pop && out_valid;
  assign out_valid = (count != '0);
  assign dout      = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  // in_ready is derived from the next count so a pop while full
  // reopens the input exactly one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != (PTR_W+1)'(DEPTH));
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result stage behind the 4-bit combinational arithmetic unit.
// Picks the 8-bit result for the issued opcode, computes {ill,dz,c,z},
// substitutes {op_a,4'hF} on divide-by-zero, and buffers results in a
// DEPTH-entry FIFO so the consumer can stall.
// Optional: define ALU_RESULT_STICKY_EN to accumulate {ill,dz,c} of every
// pushed entry into sticky_flags (cleared only by reset); otherwise
// sticky_flags is tied to zero.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake
//   opcode, op_a, op_b         issued operation and operands
//   sum..rem, carry/borrow     arithmetic-unit outputs
//   out_valid/out_ready        output handshake
//   res_data, res_flags        head result and its {ill,dz,c,z}
//   sticky_flags               accumulated {ill,dz,c}
module alu_result_stage
  import alu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] opcode,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [3:0] sum,
  input  logic       carry_out,
  input  logic [3:0] diff,
  input  logic       borrow_out,
  input  logic [7:0] prod,
  input  logic [3:0] quot,
  input  logic [3:0] rem,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_flags,
  output logic [2:0] sticky_flags
);

  alu_res_t sel, head;

  // quot/rem are never selected on divide-by-zero, so X there cannot leak.
  always_comb begin
    sel = '0;
    case (opcode)
      OP_ADD: begin
        sel.data         = {4'h0, sum};
        sel.flags[FLG_C] = carry_out;
      end
      OP_SUB: begin
        sel.data         = {4'h0, diff};
        sel.flags[FLG_C] = borrow_out;
      end
      OP_MUL: sel.data = prod;
      OP_DIV: begin
        if (op_b == 4'h0) begin
          sel.data          = {op_a, DZ_QUOT};
          sel.flags[FLG_DZ] = 1'b1;
        end else begin
          sel.data = {rem, quot};
        end
      end
      default: sel.flags[FLG_ILL] = 1'b1;
    endcase
    // Illegal opcodes leave data at zero, so z is set for them too.
    sel.flags[FLG_Z] = (sel.data == 8'h00);
  end

  alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .din       (sel),
    .in_ready  (in_ready),
    .pop       (out_ready),
    .out_valid (out_valid),
    .dout      (head)
  );

  assign res_data  = head.data;
  assign res_flags = head.flags;

`ifdef ALU_RESULT_STICKY_EN
  logic [2:0] sticky_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      sticky_q <= '0;
    else if (in_valid && in_ready)
      sticky_q <= sticky_q | {sel.flags[FLG_ILL], sel.flags[FLG_DZ], sel.flags[FLG_C]};
  end
  assign sticky_flags = sticky_q;
`else
  assign sticky_flags = 3'b000;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] opcode = '0;
  logic [3:0] op_a = '0, op_b = '0, sum = '0, diff = '0, quot = '0, rem = '0;
  logic       carry_out = 1'b0, borrow_out = 1'b0;
  logic [7:0] prod = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic [2:0] sticky_flags;

  always #5 clk = ~clk;

  alu_result_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op_a(op_a), .op_b(op_b), .sum(sum), .carry_out(carry_out),
    .diff(diff), .borrow_out(borrow_out), .prod(prod), .quot(quot), .rem(rem),
    .out_valid(out_valid), .out_ready(out_ready), .res_data(res_data),
    .res_flags(res_flags), .sticky_flags(sticky_flags)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {flags, data} per accepted push, in order.
  logic [11:0] q[$];
  logic        mdl_rdy = 1'b0;
  logic [2:0]  mdl_sticky = 3'b000;
  logic        popped = 1'b0;
  logic [11:0] pop_act, pop_exp;

  function automatic logic [11:0] res_model(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    logic [4:0] s;
    logic [7:0] d;
    logic ill, dz, c;
    ill = 1'b0; dz = 1'b0; c = 1'b0; d = 8'h00;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; d = {4'h0, s[3:0]}; c = s[4]; end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; d = {4'h0, s[3:0]}; c = (a < b); end
      3'd2: d = {4'h0, a} * {4'h0, b};
      3'd3: begin
        if (b == 4'h0) begin d = {a, 4'hF}; dz = 1'b1; end
        else begin s = {1'b0, a % b}; d[7:4] = s[3:0]; s = {1'b0, a / b}; d[3:0] = s[3:0]; end
      end
      default: ill = 1'b1;
    endcase
    return {ill, dz, c, (d == 8'h00), d};
  endfunction

  // Drives what the arithmetic unit would present for these operands.
  task automatic set_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [7:0] a8, b8;
    opcode = op; op_a = a; op_b = b;
    s = {1'b0, a} + {1'b0, b};
    sum = s[3:0]; carry_out = s[4];
    s = {1'b0, a} - {1'b0, b};
    diff = s[3:0]; borrow_out = (a < b);
    a8 = {4'h0, a}; b8 = {4'h0, b};
    prod = a8 * b8;
    if (b != 4'h0) begin quot = a / b; rem = a % b; end
    else begin quot = 4'($urandom); rem = 4'($urandom); end
  endtask

  // One clock: update the model from the inputs seen at the edge, capture
  // the DUT head if a pop happens, then return #1 after the edge.
  task automatic tick;
    logic [11:0] e;
    popped = 1'b0;
    if (rst_n) begin
      if (q.size() != 0 && out_ready) begin
        popped  = 1'b1;
        pop_exp = q.pop_front();
        pop_act = {res_flags, res_data};
      end
      if (in_valid && mdl_rdy) begin
        e = res_model(opcode, op_a, op_b);
        q.push_back(e);
`ifdef ALU_RESULT_STICKY_EN
        mdl_sticky = mdl_sticky | e[11:9];
`endif
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      mdl_rdy = 1'b0;
      mdl_sticky = 3'b000;
      popped = 1'b0;
    end else begin
      mdl_rdy = (q.size() != DEPTH);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick; tick;
    checks++;
    if ({out_valid, in_ready, res_flags, res_data, sticky_flags} !== 17'h0) begin
      errors++;
      $display("FAIL reset_state: got ov=%b ir=%b fl=%h d=%h st=%b expected all 0",
               out_valid, in_ready, res_flags, res_data, sticky_flags);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_add;
    out_ready = 1'b0;
    set_op(3'd0, 4'd9, 4'd8); in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || {res_flags, res_data} !== 12'h201) begin
      errors++;
      $display("FAIL add_9_8: got ov=%b %h expected ov=1 201", out_valid, {res_flags, res_data});
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (!popped || pop_act !== pop_exp) begin
      errors++;
      $display("FAIL add_pop: got %h expected %h (popped=%b)", pop_act, pop_exp, popped);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_div0;
    set_op(3'd3, 4'd13, 4'd0); quot = 4'hx; rem = 4'hx; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++;
    if ({res_flags, res_data} !== 12'h4DF) begin
      errors++;
      $display("FAIL div_zero: got %h expected 4df", {res_flags, res_data});
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++;
    if (!popped || pop_act !== pop_exp) begin
      errors++;
      $display("FAIL div_zero_pop: got %h expected %h", pop_act, pop_exp);
    end
    checks++;
    if (sticky_flags !== mdl_sticky) begin
      errors++;
      $display("FAIL sticky_after_dz: got %b expected %b", sticky_flags, mdl_sticky);
    end
  endtask

  task automatic test_full;
    out_ready = 1'b0;
    set_op(3'd2, 4'd15, 4'd15); in_valid = 1'b1;
    tick;
    set_op(3'd1, 4'd3, 4'd5);
    tick;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_ready: got ir=%b ov=%b expected ir=0 ov=1", in_ready, out_valid);
    end
    set_op(3'd0, 4'd1, 4'd1);
    tick;
    in_valid = 1'b0;
    checks++;
    if ({res_flags, res_data} !== 12'h0E1) begin
      errors++;
      $display("FAIL full_hold: got %h expected 0e1", {res_flags, res_data});
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (!popped || pop_act !== 12'h0E1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop1: got %h ir=%b expected 0e1 ir=1", pop_act, in_ready);
    end
    tick;
    checks++;
    if (!popped || pop_act !== 12'h20E) begin
      errors++;
      $display("FAIL full_pop2: got %h expected 20e", pop_act);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || popped) begin
      errors++;
      $display("FAIL full_third_ignored: got ov=%b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stream;
    int n;
    n = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(3'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(1, 15)));
      tick;
      if (popped) begin
        n++;
        checks++;
        if (pop_act !== pop_exp) begin
          errors++;
          $display("FAIL stream_pop: got %h expected %h", pop_act, pop_exp);
        end
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_flow: got ov=%b ir=%b expected 1 1", out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    tick;
    if (popped) begin
      n++;
      checks++;
      if (pop_act !== pop_exp) begin
        errors++;
        $display("FAIL stream_last: got %h expected %h", pop_act, pop_exp);
      end
    end
    checks++;
    if (n != 10 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_count: got %0d pops ov=%b expected 10 ov=0", n, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal;
    for (int op = 4; op < 8; op++) begin
      set_op(3'(op), 4'($urandom), 4'($urandom));
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      checks++;
      if ({res_flags, res_data} !== 12'h900) begin
        errors++;
        $display("FAIL illegal_op%0d: got %h expected 900", op, {res_flags, res_data});
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    set_op(3'd1, 4'd4, 4'd4); in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++;
    if ({res_flags, res_data} !== 12'h100) begin
      errors++;
      $display("FAIL sub_zero: got %h expected 100", {res_flags, res_data});
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    set_op(3'd0, 4'd1, 4'd2); in_valid = 1'b1;
    tick;
    set_op(3'd3, 4'd7, 4'd0);
    tick;
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0 || sticky_flags !== 3'b000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got ov=%b st=%b ir=%b expected 0 000 0", out_valid, sticky_flags, in_ready);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0 || popped) begin
        errors++;
        $display("FAIL reset_mid_flush: got ov=%b %h expected no output", out_valid, res_data);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b expected 1", in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_op(3'($urandom_range(0, 7)), 4'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
      tick;
      if (popped) begin
        checks++;
        if (pop_act !== pop_exp) begin
          errors++;
          $display("FAIL b2b_pop: got %h expected %h", pop_act, pop_exp);
        end
      end
      checks++;
      if (in_ready !== mdl_rdy || out_valid !== (q.size() != 0) || sticky_flags !== mdl_sticky) begin
        errors++;
        $display("FAIL b2b_status: got ir=%b ov=%b st=%b expected ir=%b ov=%b st=%b",
                 in_ready, out_valid, sticky_flags, mdl_rdy, (q.size() != 0), mdl_sticky);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (popped) begin
        checks++;
        if (pop_act !== pop_exp) begin
          errors++;
          $display("FAIL b2b_drain: got %h expected %h", pop_act, pop_exp);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_empty: got ov=%b left=%0d expected empty", out_valid, q.size());
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add;
    test_div0;
    test_full;
    test_stream;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
